lut_cfg_chain_loader: RTL

- Sequences programming of the LUT configuration chain for an array of `NUM_LUTS` fractured 4-input LUT cells.
- Accepts one 16-bit LUT truth table per cell over a valid/ready stream and shifts each table serially, MSB first, into the configuration shift-register chain.
- Reports completion and word-count status to the test/bring-up controller.
- Sits between the bitstream source and the chain head. It does not touch the user datapath or the carry logic.

---
 rtl/lut_cfg_pkg.sv | 30 +++
 rtl/lut_cfg_crc16.sv | 21 ++
 rtl/lut_cfg_chain_loader.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/lut_cfg_pkg.sv
// Shared types and constants for the LUT configuration chain loader.
package lut_cfg_pkg;

  localparam int unsigned LUT_WORD_W  = 16;
  localparam int unsigned WORDS_CNT_W = 9;
  localparam int unsigned BIT_CNT_W   = 4;
  localparam int unsigned GAP_CNT_W   = 4;

  localparam logic [LUT_WORD_W-1:0] CRC16_POLY = 16'h1021;
  localparam logic [LUT_WORD_W-1:0] CRC16_INIT = 16'hFFFF;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    SHIFT  = 3'd2,
    GAP    = 3'd3,
    FINISH = 3'd4
  } cfg_state_t;

  // One MSB-first CRC-16-CCITT step for a single serial bit.
  function automatic logic [LUT_WORD_W-1:0] crc16_next(
    input logic [LUT_WORD_W-1:0] crc,
    input logic                  data_bit
  );
    logic fb;
    fb = crc[LUT_WORD_W-1] ^ data_bit;
    return {crc[LUT_WORD_W-2:0], 1'b0} ^ (fb ? CRC16_POLY : '0);
  endfunction

endpackage

// File: rtl/lut_cfg_crc16.sv
// Serial CRC-16-CCITT accumulator, one bit per enabled clock.
module lut_cfg_crc16
  import lut_cfg_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  init,
  input  logic                  en,
  input  logic                  data_bit,
  output logic [LUT_WORD_W-1:0] crc
);

  always_ff @(posedge clk) begin
    if (reset || init) begin
      crc <= CRC16_INIT;
    end else if (en) begin
      crc <= crc16_next(crc, data_bit);
    end
  end

endmodule

// File: rtl/lut_cfg_chain_loader.sv
// LUT configuration chain loader: shifts 16-bit truth tables MSB first into the chain.
// Define LUT_CFG_CRC_EN to add a CRC-16-CCITT over every bit driven onto the chain.
module lut_cfg_chain_loader
  import lut_cfg_pkg::*;
#(
  parameter int unsigned NUM_LUTS   = 8,
  parameter int unsigned WORD_W     = 16,
  parameter int unsigned GAP_CYCLES = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   word_valid,
  input  logic [LUT_WORD_W-1:0]  word_data,
  output logic                   word_ready,
  output logic                   cfg_head,
  output logic                   cfg_shift_en,
  output logic                   busy,
  output logic                   done,
  output logic                   aborted,
  output logic [WORDS_CNT_W-1:0] words_loaded,
  output logic [LUT_WORD_W-1:0]  crc_out
);

  localparam logic [BIT_CNT_W-1:0]   LAST_BIT   = BIT_CNT_W'(LUT_WORD_W - 1);
  localparam logic [GAP_CNT_W-1:0]   GAP_LAST   = GAP_CNT_W'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);
  localparam logic [WORDS_CNT_W-1:0] WORDS_MAX  = WORDS_CNT_W'(NUM_LUTS);
  localparam logic [WORDS_CNT_W-1:0] WORDS_LAST = WORDS_CNT_W'(NUM_LUTS - 1);

  // Reject unsupported parameterisations at elaboration.
  if (WORD_W != LUT_WORD_W) begin : g_word_w_check
    $error("lut_cfg_chain_loader: WORD_W must be 16");
  end
  if (NUM_LUTS < 1 || NUM_LUTS > 256) begin : g_num_luts_check
    $error("lut_cfg_chain_loader: NUM_LUTS must be 1..256");
  end
  if (GAP_CYCLES > 15) begin : g_gap_check
    $error("lut_cfg_chain_loader: GAP_CYCLES must be 0..15");
  end

  cfg_state_t             state;
  logic [LUT_WORD_W-1:0]  shift_q;
  logic [BIT_CNT_W-1:0]   bit_cnt;
  logic [GAP_CNT_W-1:0]   gap_cnt;
  logic                   shift_en_q;
  logic                   abort_hit_c;

  assign abort_hit_c = abort && (state != IDLE);

  // Abort must stop the chain in the very cycle it is seen, so it gates the registered enable.
  assign cfg_shift_en = shift_en_q && !abort;
  assign cfg_head     = shift_q[LUT_WORD_W-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      shift_q      <= '0;
      bit_cnt      <= '0;
      gap_cnt      <= '0;
      shift_en_q   <= 1'b0;
      word_ready   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      aborted      <= 1'b0;
      words_loaded <= '0;
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;
      if (abort_hit_c) begin
        state      <= IDLE;
        aborted    <= 1'b1;
        busy       <= 1'b0;
        word_ready <= 1'b0;
        shift_en_q <= 1'b0;
        shift_q    <= '0;
        bit_cnt    <= '0;
        gap_cnt    <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (start) begin
              state        <= FETCH;
              busy         <= 1'b1;
              word_ready   <= 1'b1;
              words_loaded <= '0;
            end
          end
          FETCH: begin
            if (word_valid) begin
              shift_q    <= word_data;
              bit_cnt    <= '0;
              state      <= SHIFT;
              word_ready <= 1'b0;
              shift_en_q <= 1'b1;
            end
          end
          SHIFT: begin
            // Zeros fill from the right, so the head idles at 0 once a word has drained.
            shift_q <= {shift_q[LUT_WORD_W-2:0], 1'b0};
            bit_cnt <= bit_cnt + BIT_CNT_W'(1);
            if (bit_cnt == LAST_BIT) begin
              shift_en_q <= 1'b0;
              if (words_loaded != WORDS_MAX) begin
                words_loaded <= words_loaded + WORDS_CNT_W'(1);
              end
              if (words_loaded == WORDS_LAST) begin
                state <= FINISH;
                done  <= 1'b1;
                busy  <= 1'b0;
              end else if (GAP_CYCLES > 0) begin
                state   <= GAP;
                gap_cnt <= '0;
              end else begin
                state      <= FETCH;
                word_ready <= 1'b1;
              end
            end
          end
          GAP: begin
            if (gap_cnt == GAP_LAST) begin
              state      <= FETCH;
              word_ready <= 1'b1;
              gap_cnt    <= '0;
            end else begin
              gap_cnt <= gap_cnt + GAP_CNT_W'(1);
            end
          end
          FINISH: begin
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

`ifdef LUT_CFG_CRC_EN
  logic crc_init_c;

  assign crc_init_c = (state == IDLE) && start;

  lut_cfg_crc16 u_crc (
    .clk      (clk),
    .reset    (reset),
    .init     (crc_init_c),
    .en       (cfg_shift_en),
    .data_bit (cfg_head),
    .crc      (crc_out)
  );
`else
  assign crc_out = '0;
`endif

endmodule
